// File: rtl/c9_bist_pkg.sv
// Shared types and constants for the C9 BIST sequencer.
// The optional signature register (C9_BIST_SISR_EN) uses the SISR constants and step function.
package c9_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  localparam int N_IN_DEF = 4;
  localparam int N_VEC    = 2 ** N_IN_DEF;
  localparam int SET_W    = 4;                 // settle counter covers 0..15
  localparam int ERR_W    = $clog2(N_VEC + 1);

  // x^16 + x^12 + x^5 + 1, x^16 implied by the shift-out
  localparam logic [15:0] SISR_POLY = 16'h1021;
  localparam logic [15:0] SISR_SEED = 16'hFFFF;

  function automatic logic [15:0] sisr_step(input logic [15:0] s, input logic din);
    logic fb;
    fb = s[15] ^ din;
    return {s[14:0], 1'b0} ^ (fb ? SISR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/c9_bist_sisr.sv
// Serial-input signature register compressing the CUT response stream.
// Only built when C9_BIST_SISR_EN is defined.
`ifdef C9_BIST_SISR_EN
module c9_bist_sisr
  import c9_bist_pkg::*;
(
  input  logic        CK,
  input  logic        RST,
  input  logic        clr,
  input  logic        shift,
  input  logic        din,
  output logic [15:0] sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = SISR_SEED;
    end else if (shift) begin
      sig_d = sisr_step(sig_q, din);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      sig_q <= SISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule
`endif

// File: rtl/c9_bist_sequencer.sv
// Exhaustive BIST sequencer for the 4-in/1-out C9 netlist: steps vectors, settles, compares to GOLDEN.
// Optional signature output sig[15:0] when C9_BIST_SISR_EN is defined.
module c9_bist_sequencer
  import c9_bist_pkg::*;
#(
  parameter int                  N_IN   = 4,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  GOLDEN = {(2**N_IN){1'b1}}
) (
  input  logic                            CK,
  input  logic                            RST,
  input  logic                            start,
  input  logic                            cut_out,
  output logic [N_IN-1:0]                 cut_in,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [$clog2(2**N_IN+1)-1:0]    err_cnt,
  output logic                            fail_valid,
  output logic [N_IN-1:0]                 fail_vec
`ifdef C9_BIST_SISR_EN
  ,
  output logic [15:0]                     sig
`endif
);

  localparam int                NV       = 2 ** N_IN;
  localparam int                EW       = $clog2(NV + 1);
  localparam logic [SET_W-1:0]  SETTLE_L = SET_W'(SETTLE);
  localparam logic [N_IN-1:0]   LAST_VEC = N_IN'(NV - 1);

  state_t           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  cut_in_q, cut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [EW-1:0]    err_q, err_d;
  logic             fv_q, fv_d;
  logic [N_IN-1:0]  fvec_q, fvec_d;

  logic             mismatch;
  logic [EW-1:0]    err_inc;

  assign mismatch = (cut_out != GOLDEN[cut_in_q]);
  assign err_inc  = err_q + EW'(mismatch);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cut_in_d = cut_in_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fvec_d   = fvec_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cut_in_d = '0;
          busy_d   = 1'b1;
          err_d    = '0;
          fv_d     = 1'b0;
          fvec_d   = '0;
          pass_d   = 1'b0;
          cnt_d    = SETTLE_L;
          state_d  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // Counter value 1 marks the last settle cycle of this vector.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SET_W'(1);
        end
        if (cnt_q <= SET_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        err_d = err_inc;
        if (mismatch && !fv_q) begin
          fv_d   = 1'b1;
          fvec_d = cut_in_q;
        end
        if (cut_in_q == LAST_VEC) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0);
        end else begin
          cut_in_d = cut_in_q + N_IN'(1);
          cnt_d    = SETTLE_L;
          state_d  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cut_in_q <= cut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fvec_q   <= fvec_d;
    end
  end

  assign cut_in     = cut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

`ifdef C9_BIST_SISR_EN
  logic sisr_clr;
  logic sisr_shift;

  assign sisr_clr   = (state_q == ST_IDLE) && start;
  assign sisr_shift = (state_q == ST_SAMPLE);

  c9_bist_sisr u_sisr (
    .CK    (CK),
    .RST   (RST),
    .clr   (sisr_clr),
    .shift (sisr_shift),
    .din   (cut_out),
    .sig   (sig)
  );
`endif

endmodule

// File: tb/tb_c9_bist_sequencer.sv
// Scoreboard bench for c9_bist_sequencer: two instances (SETTLE=2 and SETTLE=0) driven by a behavioural CUT.
// Signature checks are active when C9_BIST_SISR_EN is defined.
module tb_c9_bist_sequencer;

  localparam int SA = 2;
  localparam int SB = 0;
  localparam logic [15:0] GOLD = 16'hFFFF;

  typedef struct {
    int unsigned start_edge;
    int unsigned done_cyc;
    logic [4:0]  err;
    logic        fv;
    logic [3:0]  fvec;
    logic        pass;
    logic [15:0] sig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] mask = 16'hFFFF;

  logic [3:0]  cut_in_a, cut_in_b, fvec_a, fvec_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
  logic [4:0]  err_a, err_b;
  logic        cut_out_a, cut_out_b;
  logic [15:0] sig_a, sig_b;

  int unsigned cyc = 0;
  int          nchk = 0;
  int          nbad = 0;
  int          bcnt [2];
  exp_t        sb [2][$];

  // Behavioural CUT: response to vector v is mask[v].
  assign cut_out_a = mask[cut_in_a];
  assign cut_out_b = mask[cut_in_b];

`ifndef C9_BIST_SISR_EN
  assign sig_a = 16'h0;
  assign sig_b = 16'h0;
`endif

  c9_bist_sequencer #(.N_IN(4), .SETTLE(SA), .GOLDEN(GOLD)) dut_a (
    .CK(clk), .RST(rst), .start(start_a), .cut_out(cut_out_a),
    .cut_in(cut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .fail_valid(fv_a), .fail_vec(fvec_a)
`ifdef C9_BIST_SISR_EN
    , .sig(sig_a)
`endif
  );

  c9_bist_sequencer #(.N_IN(4), .SETTLE(SB), .GOLDEN(GOLD)) dut_b (
    .CK(clk), .RST(rst), .start(start_b), .cut_out(cut_out_b),
    .cut_in(cut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .fail_valid(fv_b), .fail_vec(fvec_b)
`ifdef C9_BIST_SISR_EN
    , .sig(sig_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: walk every vector, count responses differing from the golden table,
  // and fold the response stream through the CRC-16 (x^16+x^12+x^5+1) polynomial.
  function automatic exp_t model(input logic [15:0] m, input int unsigned s_edge, input int settle);
    exp_t        e;
    logic [15:0] g;
    logic [15:0] taps;
    logic        fb;
    g = GOLD;
    taps = 16'((1 << 12) | (1 << 5) | 1);
    e.start_edge = s_edge;
    e.done_cyc   = s_edge + 16 * (settle + 1);
    e.err  = 5'd0;
    e.fv   = 1'b0;
    e.fvec = 4'd0;
    e.sig  = 16'hFFFF;
    for (int v = 0; v < 16; v++) begin
      if (m[v] != g[v]) begin
        e.err = e.err + 5'd1;
        if (!e.fv) begin
          e.fv   = 1'b1;
          e.fvec = 4'(v);
        end
      end
      fb = e.sig[15] ^ m[v];
      e.sig = e.sig << 1;
      if (fb) e.sig = e.sig ^ taps;
    end
    e.pass = (e.err == 5'd0);
    return e;
  endfunction

  task automatic mon(input int sd, input int settle, input logic [3:0] ci, input logic bz,
                     input logic dn, input logic ps, input logic [4:0] ec, input logic fv,
                     input logic [3:0] fvec, input logic [15:0] sg);
    exp_t        e;
    int unsigned j;
    string       tag;
    tag = (sd == 0) ? "a" : "b";
    if (rst) begin
      bcnt[sd] = 0;
      return;
    end
    if (bz) begin
      bcnt[sd]++;
      if (sb[sd].size() > 0) begin
        j = cyc - sb[sd][0].start_edge;
        chk({"cut_in_", tag}, 32'(ci), 32'(j / (settle + 1)));
      end else begin
        chk({"busy_unexpected_", tag}, 32'(bz), 32'(0));
      end
    end
    if (dn) begin
      if (sb[sd].size() == 0) begin
        chk({"done_unexpected_", tag}, 32'(dn), 32'(0));
      end else begin
        e = sb[sd].pop_front();
        chk({"done_cycle_", tag}, cyc, e.done_cyc);
        chk({"busy_len_", tag}, 32'(bcnt[sd]), 32'(16 * (settle + 1)));
        chk({"err_cnt_", tag}, 32'(ec), 32'(e.err));
        chk({"fail_valid_", tag}, 32'(fv), 32'(e.fv));
        if (e.fv) chk({"fail_vec_", tag}, 32'(fvec), 32'(e.fvec));
        chk({"pass_", tag}, 32'(ps), 32'(e.pass));
`ifdef C9_BIST_SISR_EN
        chk({"sig_", tag}, 32'(sg), 32'(e.sig));
`endif
        $display("run %s done: mask=%04h err=%0d fv=%0d fvec=%0d pass=%0d sig=%04h at cycle %0d",
                 tag, mask, ec, fv, fvec, ps, sg, cyc);
      end
      bcnt[sd] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, SA, cut_in_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a, sig_a);
    mon(1, SB, cut_in_b, busy_b, done_b, pass_b, err_b, fv_b, fvec_b, sig_b);
  end

  task automatic wait_empty(input int sd);
    for (int i = 0; i < 400 && sb[sd].size() != 0; i++) @(posedge clk);
    if (sb[sd].size() != 0) begin
      chk("run_timeout", 32'(sb[sd].size()), 32'(0));
      sb[sd].delete();
    end
    @(posedge clk);
  endtask

  task automatic launch(input int sd, input logic [15:0] m);
    @(posedge clk); #1;
    mask = m;
    sb[sd].push_back(model(m, cyc + 1, (sd == 0) ? SA : SB));
    if (sd == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    wait_empty(sd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned s;
    logic [15:0] m;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cut_in", 32'(cut_in_a), 32'(0));
    chk("rst_busy", 32'(busy_a | busy_b), 32'(0));
    chk("rst_done", 32'(done_a | done_b), 32'(0));
    chk("rst_pass", 32'(pass_a | pass_b), 32'(0));
    chk("rst_err", 32'(err_a), 32'(0));
    chk("rst_fail", 32'({fv_a, fvec_a}), 32'(0));
`ifdef C9_BIST_SISR_EN
    chk("rst_sig", 32'(sig_a), 32'(16'hFFFF));
`endif

    // Directed runs: all good, all bad, failures at vectors 5 and 15.
    launch(0, 16'hFFFF);
    launch(0, 16'h0000);
    launch(0, 16'h7FDF);
    for (int i = 0; i < 5; i++) launch(0, 16'($urandom) | 16'($urandom));

    // start held high across two runs; relaunch sampled the edge after done.
    @(posedge clk); #1;
    m = 16'($urandom) & 16'hFEFF;
    mask = m;
    s = cyc + 1;
    sb[0].push_back(model(m, s, SA));
    sb[0].push_back(model(m, s + 16 * (SA + 1) + 1, SA));
    start_a = 1'b1;
    while (cyc < s + 16 * (SA + 1) + 1) @(posedge clk);
    #1 start_a = 1'b0;
    wait_empty(0);

    // start pulse in the middle of a run must not disturb it.
    @(posedge clk); #1;
    m = 16'($urandom);
    mask = m;
    sb[0].push_back(model(m, cyc + 1, SA));
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (10) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_empty(0);

    // Reset while cut_in = 7 aborts the run.
    @(posedge clk); #1;
    mask = 16'hFFFF;
    s = cyc + 1;
    sb[0].push_back(model(16'hFFFF, s, SA));
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    while (cyc < s + 7 * (SA + 1) + 1) @(posedge clk);
    #1 rst = 1'b1;
    sb[0].delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_cut_in", 32'(cut_in_a), 32'(0));
    chk("abort_busy", 32'(busy_a), 32'(0));
    chk("abort_done", 32'(done_a), 32'(0));
    chk("abort_err", 32'(err_a), 32'(0));
    chk("abort_pass", 32'(pass_a), 32'(0));
    $display("reset abort checked at cycle %0d", cyc);
    launch(0, 16'hFFFF);

    // SETTLE = 0 instance.
    launch(1, 16'hFFFF);
    launch(1, 16'h0000);
    launch(1, 16'h7FDF);
    for (int i = 0; i < 3; i++) launch(1, 16'($urandom));

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/c9_bist_sequencer.md
Name: c9_bist_sequencer

Overview:
Built-in self-test controller for the 4-input / 1-output C9 combinational benchmark netlist (the cell under test, CUT).
- Drives every input vector exhaustively, in ascending order, onto the CUT inputs.
- Waits a programmable number of settle cycles per vector, then samples the CUT output and compares it against a golden truth table.
- Reports pass/fail, the error count and the first failing vector.
- Sits between the fault-injection/test harness and the gate-level CUT instance.

Parameters:
- N_IN, 4, CUT input width. N_VEC = 2**N_IN.
- SETTLE, 2, settle cycles per vector before sampling. Range 0..15.
- GOLDEN, 16'hFFFF, expected CUT output; bit i is the response to vector i. Width N_VEC. The C9 function reduces to constant 1.

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- cut_out  input  1  CUT response (G5gat).
- cut_in  output  N_IN  vector driven to the CUT (G1gat = bit 0 … G4gat = bit 3); registered.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  last run had zero mismatches; valid when busy = 0.
- err_cnt  output  clog2(N_VEC+1)  mismatch count of the last or current run.
- fail_valid  output  1  at least one mismatch seen.
- fail_vec  output  N_IN  first mismatching vector; valid when fail_valid = 1.

Behaviour:
Reset:
- All outputs are 0, state = IDLE, internal settle counter = 0.
- RST asserted at any time, including mid-run, aborts the run. On the next edge: cut_in = 0, busy = 0, done = 0, pass = 0.

FSM states: IDLE, SETTLE, SAMPLE.

IDLE:
- On start = 1:
  - cut_in <= 0, busy <= 1.
  - err_cnt <= 0, fail_valid <= 0, fail_vec <= 0, pass <= 0.
  - Load the settle counter with SETTLE.
  - Go to SETTLE, or to SAMPLE directly if SETTLE = 0.
- start = 0: stay in IDLE and hold the previous results.

SETTLE:
- Decrement the settle counter.
- When it reaches 1 (i.e. after SETTLE cycles in this state), go to SAMPLE.

SAMPLE (exactly one cycle):
- Compare cut_out with GOLDEN[cut_in].
- On mismatch:
  - err_cnt++.
  - If fail_valid = 0: set fail_valid = 1 and fail_vec = cut_in.
- If cut_in = N_VEC-1:
  - Go to IDLE.
  - busy <= 0, done <= 1 for one cycle.
  - pass <= (final err_cnt == 0), including any mismatch at the final vector.
- Otherwise: cut_in++, reload the settle counter, go to SETTLE (or stay in SAMPLE if SETTLE = 0).

Timing and boundary rules:
- Each vector occupies SETTLE+1 cycles.
- done rises N_VEC*(SETTLE+1) edges after the edge that sampled start.
- busy is high for exactly those cycles.
- start while busy is ignored.
- start held high re-launches a run the cycle after done, because IDLE is re-entered and start is sampled there.
- err_cnt cannot overflow (max N_VEC); no saturation logic.
- cut_in is a register, so the CUT sees a glitch-free change once per vector.
- Wrap of cut_in from N_VEC-1 never occurs; the run ends instead.

Optional Feature:
Macro: C9_BIST_SISR_EN.
- Defined:
  - Adds output sig[15:0]: a 16-bit serial-input signature register, polynomial x^16+x^12+x^5+1, seed 16'hFFFF.
  - Cleared to the seed on start and on RST.
  - Shifts in cut_out on every SAMPLE cycle.
  - Holds its value in IDLE.
- Undefined: no sig port, no signature logic; all other behaviour is identical.

Decomposition:
- Package c9_bist_pkg:
  - state typedef (IDLE/SETTLE/SAMPLE).
  - localparams: N_VEC, counter widths, SISR polynomial and seed.
- Sub-module c9_bist_sisr, present only under C9_BIST_SISR_EN:
  - Ports: CK, RST, clr, shift, din, sig.

Test Plan:
1. SETTLE = 2, cut_out tied 1, pulse start → cut_in steps 0..15, holding each for 3 cycles. done at edge 48 after start; pass = 1, err_cnt = 0, fail_valid = 0.
2. cut_out tied 0 → err_cnt = 16, fail_valid = 1, fail_vec = 0, pass = 0.
3. Behavioural CUT returns 0 only when cut_in = 5, and also when cut_in = 15 → err_cnt = 2, fail_vec = 5, pass = 0. This covers a mismatch on the final vector.
4. start held high across two runs → second busy rises the cycle after the first done. Results are cleared at relaunch; a start pulse while busy has no effect on timing.
5. RST asserted while cut_in = 7 → next edge: cut_in = 0, busy = 0, done = 0, err_cnt = 0. A subsequent start runs a full 48-cycle sequence.
6. SETTLE = 0 with C9_BIST_SISR_EN, cut_out tied 1 → done 16 cycles after start. sig equals the reference-model signature after 16 ones from seed 16'hFFFF.
